bist_prpg_misr: RTL and testbench
=================================

// Module: bist_prpg_misr
// PURPOSE
//  Multi-channel BIST engine for the systolic array: NUM_CH independent Fibonacci XNOR LFSRs.
//  PRPG mode: streams pseudo-random operand patterns into the array over a valid/ready handshake.
//  MISR mode: compacts array responses into per-channel signatures.
//  Next-generation BIST LFSR: adds width-generic taps, channels, pattern count/stop-code termination,
//  backpressure, abort and signature mode. Sits between the BIST controller and the array edge.
// PARAMETERS
//  WIDTH   64  LFSR width per channel; legal 8,16,32,64 (taps from package table; other values -> elab $error)
//  NUM_CH  4   number of parallel LFSR channels (>=1)
//  CNT_W   32  width of pattern/response counter
// PORTS
//  clk_i          in   1             clock
//  rstn_i         in   1             async active-low reset
//  start_i        in   1             begin run; sampled in IDLE or DONE only
//  abort_i        in   1             return to IDLE; highest priority
//  mode_i         in   1             0=PRPG, 1=MISR; latched at start
//  num_pat_i      in   CNT_W         beats to run; latched at start
//  seed_i         in   NUM_CH*WIDTH  per-channel seeds (ch k = bits [k*WIDTH +: WIDTH])
//  stop_code_i    in   WIDTH         PRPG early-stop code, compared on ch0; latched at start
//  stop_en_i      in   1             enable stop-code termination; latched at start
//  pat_valid_o    out  1             pattern valid (PRPG, RUN)
//  pat_ready_i    in   1             consumer accepts pattern
//  pat_data_o     out  NUM_CH*WIDTH  current LFSR states
//  resp_valid_i   in   1             response beat (MISR); engine is always ready
//  resp_data_i    in   NUM_CH*WIDTH  response data to compact
//  sig_o          out  NUM_CH*WIDTH  = LFSR states (signature when done_o in MISR)
//  cnt_o          out  CNT_W         beats accepted/compacted this run
//  busy_o         out  1             state==RUN
//  done_o         out  1             state==DONE
//  stopped_o      out  1             run ended by stop-code match (sticky until next start)
//  seed_err_o     out  1             some channel seeded all-ones (XNOR lock-up); sticky until next start
// BEHAVIOUR
//  Reset: FSM=IDLE; all LFSR states, cnt_o = 0; every 1-bit output = 0.
//  Feedback: fb = ~^(taps of state), taps 1-based per XAPP052
//    (8:8,6,5,4  16:16,15,13,4  32:32,22,2,1  64:64,63,61,60; bit n -> index n-1).
//  Step: state <= {state[WIDTH-2:0], fb}. MISR step: ({state[WIDTH-2:0], fb}) ^ resp.
//  FSM IDLE/DONE --start_i--> RUN, same edge: load seeds; latch mode/num_pat/stop; cnt=0;
//    stopped/seed_err cleared, then seed_err set if any seed == '1.
//    If latched num_pat==0, go straight to DONE (seeds loaded, zero beats).
//  RUN/PRPG: pat_valid_o=1 (combinational from state); first beat = seed.
//    On valid&ready: all channels step, cnt+1.
//    Last beat (cnt==num_pat-1) or (stop_en && ch0 state==stop_code) -> DONE after that accept.
//    Stop match is inclusive; it also sets stopped_o. No ready -> state, data held stable.
//  RUN/MISR: pat_valid_o=0. Each resp_valid_i cycle: compact all channels, cnt+1.
//    The num_pat-th response -> DONE. Stop code is ignored.
//  DONE: holds states/cnt; done_o=1 until start_i (restart) or abort_i.
//  abort_i in any state: -> IDLE next edge; LFSR states and cnt held; done/stopped cleared.
//    abort_i wins over start_i and over same-cycle accept (no step).
//  start_i while RUN: ignored. Input changes during RUN have no effect (all latched).
//  cnt saturates never: num_pat <= 2^CNT_W-1 bounds it. All-ones state self-loops in PRPG (flagged, not fixed).
// STRUCTURE
//  Package bist_pkg:
//    bist_mode_e {BIST_PRPG, BIST_MISR}; bist_state_e {IDLE, RUN, DONE};
//    function lfsr_taps(width) returning a WIDTH-bit tap mask.
//  Sub-module bist_lfsr_ch (one per channel via generate):
//    load/step/compact controls, seed, resp in, state out; XNOR feedback from mask.
//  Top holds FSM, counter, latched config, stop compare, flags.
// TESTING
//  1 WIDTH=8,NUM_CH=1, seed 8'h00, num_pat=3, ready=1
//    -> pat_data 00,01,03; cnt_o=3; done_o the cycle after 3rd accept.
//  2 PRPG with pat_ready_i toggling 1010..
//    -> pat_data changes only after accept cycles; sequence identical to test 1.
//  3 stop_en=1, stop_code=8'h03, num_pat=100
//    -> DONE after beat 3; stopped_o=1, cnt_o=3.
//  4 MISR, seed 0, 4 resp beats with random gaps
//    -> sig_o equals reference model; cnt_o=4; gaps do not step.
//  5 seed 8'hFF -> seed_err_o=1, pat_data stays FF; num_pat=0 -> DONE immediately, cnt_o=0.
//  6 abort_i mid-run (incl. same cycle as start/accept)
//    -> IDLE, busy/done=0, no step; async rstn_i mid-run -> all outputs 0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and XNOR tap table for the BIST PRPG/MISR engine.
package bist_pkg;

    typedef enum logic {
        BIST_PRPG = 1'b0,
        BIST_MISR = 1'b1
    } bist_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_e;

    localparam int unsigned MAX_WIDTH = 64;

    function automatic bit lfsr_width_ok(input int unsigned width);
        return (width == 8) || (width == 16) || (width == 32) || (width == 64);
    endfunction

    // Right-aligned tap mask; 1-based tap n lands on bit n-1.
    function automatic logic [MAX_WIDTH-1:0] lfsr_taps(input int unsigned width);
        logic [MAX_WIDTH-1:0] mask;
        mask = '0;
        case (width)
            8:       mask[7:0]  = 8'hB8;
            16:      mask[15:0] = 16'hD008;
            32:      mask[31:0] = 32'h8020_0003;
            64:      mask       = 64'hD800_0000_0000_0000;
            default: mask       = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bist_lfsr_ch.sv
// One Fibonacci XNOR LFSR channel: seed load, free step, or step-and-compact.
module bist_lfsr_ch
    import bist_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             compact_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [WIDTH-1:0] resp_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] shifted;
    logic             fb;

    always_comb begin
        fb      = ~^(state_q & TAPS);
        shifted = {state_q[WIDTH-2:0], fb};
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = shifted;
        end else if (compact_i) begin
            state_d = shifted ^ resp_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_o = state_q;
    end

endmodule

// File: rtl/bist_prpg_misr.sv
// Multi-channel BIST engine: pattern generator over valid/ready or response compactor,
// with beat count / stop-code termination and abort.
module bist_prpg_misr
    import bist_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    mode_i,
    input  logic [CNT_W-1:0]        num_pat_i,
    input  logic [NUM_CH*WIDTH-1:0] seed_i,
    input  logic [WIDTH-1:0]        stop_code_i,
    input  logic                    stop_en_i,
    output logic                    pat_valid_o,
    input  logic                    pat_ready_i,
    output logic [NUM_CH*WIDTH-1:0] pat_data_o,
    input  logic                    resp_valid_i,
    input  logic [NUM_CH*WIDTH-1:0] resp_data_i,
    output logic [NUM_CH*WIDTH-1:0] sig_o,
    output logic [CNT_W-1:0]        cnt_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    stopped_o,
    output logic                    seed_err_o
);

    if (!lfsr_width_ok(WIDTH)) begin : g_width_chk
        $error("bist_prpg_misr: WIDTH %0d has no tap table entry", WIDTH);
    end
    if (NUM_CH < 1) begin : g_ch_chk
        $error("bist_prpg_misr: NUM_CH must be at least 1");
    end

    bist_state_e             state_q, state_d;
    bist_mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        num_pat_q, num_pat_d;
    logic [WIDTH-1:0]        stop_code_q, stop_code_d;
    logic                    stop_en_q, stop_en_d;
    logic                    stopped_q, stopped_d;
    logic                    seed_err_q, seed_err_d;

    logic [NUM_CH*WIDTH-1:0] lfsr_state;
    logic [NUM_CH-1:0]       seed_ones;
    logic                    load;
    logic                    accept;
    logic                    compact;
    logic                    last_beat;
    logic                    stop_hit;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign seed_ones[k] = (seed_i[k*WIDTH +: WIDTH] == '1);

        bist_lfsr_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk_i     (clk_i),
            .rstn_i    (rstn_i),
            .load_i    (load),
            .step_i    (accept),
            .compact_i (compact),
            .seed_i    (seed_i[k*WIDTH +: WIDTH]),
            .resp_i    (resp_data_i[k*WIDTH +: WIDTH]),
            .state_o   (lfsr_state[k*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            mode_q      <= BIST_PRPG;
            cnt_q       <= '0;
            num_pat_q   <= '0;
            stop_code_q <= '0;
            stop_en_q   <= 1'b0;
            stopped_q   <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            num_pat_q   <= num_pat_d;
            stop_code_q <= stop_code_d;
            stop_en_q   <= stop_en_d;
            stopped_q   <= stopped_d;
            seed_err_q  <= seed_err_d;
        end
    end

    always_comb begin
        last_beat = (cnt_q == num_pat_q - CNT_W'(1));
        stop_hit  = stop_en_q && (lfsr_state[WIDTH-1:0] == stop_code_q);
    end

    // Abort gates every strobe, so it also suppresses a same-cycle load, accept or compact.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        num_pat_d   = num_pat_q;
        stop_code_d = stop_code_q;
        stop_en_d   = stop_en_q;
        stopped_d   = stopped_q;
        seed_err_d  = seed_err_q;
        load        = 1'b0;
        accept      = 1'b0;
        compact     = 1'b0;
        if (abort_i) begin
            state_d   = IDLE;
            stopped_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        load        = 1'b1;
                        mode_d      = bist_mode_e'(mode_i);
                        num_pat_d   = num_pat_i;
                        stop_code_d = stop_code_i;
                        stop_en_d   = stop_en_i;
                        cnt_d       = '0;
                        stopped_d   = 1'b0;
                        seed_err_d  = |seed_ones;
                        state_d     = (num_pat_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (mode_q == BIST_PRPG) begin
                        if (pat_ready_i) begin
                            accept = 1'b1;
                            cnt_d  = cnt_q + CNT_W'(1);
                            if (stop_hit) begin
                                stopped_d = 1'b1;
                            end
                            if (last_beat || stop_hit) begin
                                state_d = DONE;
                            end
                        end
                    end else begin
                        if (resp_valid_i) begin
                            compact = 1'b1;
                            cnt_d   = cnt_q + CNT_W'(1);
                            if (last_beat) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o      = (state_q == RUN);
        done_o      = (state_q == DONE);
        pat_valid_o = (state_q == RUN) && (mode_q == BIST_PRPG);
        pat_data_o  = lfsr_state;
        sig_o       = lfsr_state;
        cnt_o       = cnt_q;
        stopped_o   = stopped_q;
        seed_err_o  = seed_err_q;
    end

endmodule

// File: tb/tb_bist_prpg_misr.sv
// Bench for bist_prpg_misr at WIDTH=8, NUM_CH=2: vector table plus abort/reset sequences.
module tb_bist_prpg_misr;

    localparam int W   = 8;
    localparam int NCH = 2;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           rstn;
    logic           start_i, abort_i, mode_i, stop_en_i, pat_ready_i, resp_valid_i;
    logic [CW-1:0]  num_pat_i;
    logic [NCH*W-1:0] seed_i, resp_data_i;
    logic [W-1:0]   stop_code_i;
    logic           pat_valid_o, busy_o, done_o, stopped_o, seed_err_o;
    logic [NCH*W-1:0] pat_data_o, sig_o;
    logic [CW-1:0]  cnt_o;

    bist_prpg_misr #(
        .WIDTH  (W),
        .NUM_CH (NCH),
        .CNT_W  (CW)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .mode_i       (mode_i),
        .num_pat_i    (num_pat_i),
        .seed_i       (seed_i),
        .stop_code_i  (stop_code_i),
        .stop_en_i    (stop_en_i),
        .pat_valid_o  (pat_valid_o),
        .pat_ready_i  (pat_ready_i),
        .pat_data_o   (pat_data_o),
        .resp_valid_i (resp_valid_i),
        .resp_data_i  (resp_data_i),
        .sig_o        (sig_o),
        .cnt_o        (cnt_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .stopped_o    (stopped_o),
        .seed_err_o   (seed_err_o)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [NCH*W-1:0] exp_q[$];

    typedef struct {
        logic           mode;
        logic [NCH*W-1:0] seed;
        logic [CW-1:0]  npat;
        logic           sen;
        logic [W-1:0]   scode;
        int             rdy;       // 0 always ready, 1 toggling 1010, 2 random
        int unsigned    exp_cnt;
        logic           exp_stop;
        logic           exp_serr;
    } vec_t;

    vec_t vecs[9];

    // x^8+x^6+x^5+x^4 XNOR feedback written out bit by bit.
    function automatic logic [W-1:0] ref_step(input logic [W-1:0] s);
        return {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
    endfunction

    function automatic logic [NCH*W-1:0] step_all(input logic [NCH*W-1:0] s);
        logic [NCH*W-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) r[k*W +: W] = ref_step(s[k*W +: W]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted beat must match the next queued pattern; stalled data must hold.
    logic [NCH*W-1:0] held_data;
    logic             held = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            held = 1'b0;
        end else begin
            if (held && pat_valid_o) check("pat_hold", pat_data_o, held_data);
            held = 1'b0;
            if (pat_valid_o && !abort_i) begin
                if (pat_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL pat_unexpected: got 0x%0h expected no beat", pat_data_o);
                    end else begin
                        check("pat_data", pat_data_o, exp_q.pop_front());
                    end
                end else begin
                    held      = 1'b1;
                    held_data = pat_data_o;
                end
            end
        end
    end

    task automatic idle_inputs();
        start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0; stop_en_i = 1'b0;
        pat_ready_i = 1'b0; resp_valid_i = 1'b0; num_pat_i = '0;
        seed_i = '0; resp_data_i = '0; stop_code_i = '0;
    endtask

    task automatic start_run(input logic mode, input logic [NCH*W-1:0] seed, input logic [CW-1:0] npat,
                             input logic sen, input logic [W-1:0] scode);
        @(posedge clk); #1;
        start_i = 1'b1; mode_i = mode; num_pat_i = npat; seed_i = seed;
        stop_en_i = sen; stop_code_i = scode; pat_ready_i = 1'b0; resp_valid_i = 1'b0;
        @(posedge clk); #1;
        // Scramble configuration after the start edge; the engine must use the latched copy.
        start_i = 1'b0; mode_i = ~mode; num_pat_i = CW'($urandom); seed_i = NCH*W'($urandom);
        stop_en_i = ~sen; stop_code_i = W'($urandom);
    endtask

    task automatic do_run(input vec_t v);
        logic [NCH*W-1:0] s;
        int unsigned beats, got, cyc;
        logic stop;
        s = v.seed; beats = 0; got = 0; cyc = 0; stop = 1'b0;
        if (v.mode == 1'b0) begin
            for (int i = 0; i < int'(v.npat); i++) begin
                exp_q.push_back(s);
                beats++;
                stop = v.sen && (s[W-1:0] == v.scode);
                s = step_all(s);
                if (stop) break;
            end
        end
        start_run(v.mode, v.seed, v.npat, v.sen, v.scode);
        if (v.mode == 1'b0) begin
            while (cyc < 1000 && !done_o) begin
                case (v.rdy)
                    0:       pat_ready_i = 1'b1;
                    1:       pat_ready_i = (cyc % 2 == 0);
                    default: pat_ready_i = 1'($urandom_range(0, 1));
                endcase
                @(posedge clk); #1;
                cyc++;
            end
            pat_ready_i = 1'b0;
            if (v.rdy == 0) check("latency_ready", cyc, beats);
            if (v.rdy == 1 && beats > 0) check("latency_toggle", cyc, 2 * beats - 1);
        end else begin
            while (cyc < 1000 && got < int'(v.npat)) begin
                resp_valid_i = ($urandom_range(0, 2) != 0);
                resp_data_i  = NCH*W'($urandom);
                if (cyc == 0) check("misr_no_valid", pat_valid_o, 0);
                if (resp_valid_i) begin
                    s = step_all(s) ^ resp_data_i;
                    got++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            resp_valid_i = 1'b0;
            resp_data_i  = NCH*W'($urandom);
            beats = got;
        end
        check("done", done_o, 1);
        check("busy", busy_o, 0);
        check("cnt", cnt_o, v.exp_cnt);
        check("cnt_model", cnt_o, beats);
        check("stopped", stopped_o, v.exp_stop);
        check("seed_err", seed_err_o, v.exp_serr);
        check("sig", sig_o, s);
        check("queue_empty", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("done_hold", done_o, 1);
        check("sig_hold", sig_o, s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH*W-1:0] s;

        vecs[0] = '{1'b0, 16'h5A00, 16'd3,   1'b0, 8'h00, 0, 3,  1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h5A00, 16'd3,   1'b0, 8'h00, 1, 3,  1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h1200, 16'd100, 1'b1, 8'h03, 0, 3,  1'b1, 1'b0};
        vecs[3] = '{1'b1, 16'h0000, 16'd4,   1'b0, 8'h00, 0, 4,  1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'h00FF, 16'd5,   1'b0, 8'h00, 0, 5,  1'b0, 1'b1};
        vecs[5] = '{1'b0, 16'h3400, 16'd0,   1'b0, 8'h00, 0, 0,  1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'hFF37, 16'd6,   1'b1, 8'h37, 0, 6,  1'b0, 1'b1};
        vecs[7] = '{1'b0, 16'hC3A5, 16'd20,  1'b0, 8'h00, 2, 20, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 16'h0300, 16'd2,   1'b1, 8'h03, 0, 2,  1'b0, 1'b0};

        idle_inputs();
        rstn = 1'b0;
        #12;
        check("rst_valid", pat_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_cnt", cnt_o, 0);
        check("rst_sig", sig_o, 0);
        check("rst_flags", {stopped_o, seed_err_o}, 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 9; i++) do_run(vecs[i]);

        // Abort coinciding with an accept: no step, counter held, back to IDLE.
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0101);
        start_run(1'b0, 16'h0000, 16'd10, 1'b0, 8'h00);
        pat_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        pat_ready_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_valid", pat_valid_o, 0);
        check("abort_cnt", cnt_o, 2);
        check("abort_data", pat_data_o, 16'h0303);
        check("abort_queue", exp_q.size(), 0);

        // Start and abort together: abort wins, seeds are not loaded.
        @(posedge clk); #1;
        start_i = 1'b1; abort_i = 1'b1; seed_i = 16'hFFFF; num_pat_i = 16'd5;
        @(posedge clk); #1;
        start_i = 1'b0; abort_i = 1'b0;
        check("startabort_busy", busy_o, 0);
        check("startabort_sig", sig_o, 16'h0303);
        check("startabort_serr", seed_err_o, 0);

        // start_i pulsed while running must be ignored.
        s = 16'h1100;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(s);
            s = step_all(s);
        end
        start_run(1'b0, 16'h1100, 16'd4, 1'b0, 8'h00);
        pat_ready_i = 1'b1;
        start_i = 1'b1; seed_i = 16'hFFFF; num_pat_i = 16'd0;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 0; c < 50 && !done_o; c++) begin
            @(posedge clk); #1;
        end
        pat_ready_i = 1'b0;
        check("runstart_done", done_o, 1);
        check("runstart_cnt", cnt_o, 4);
        check("runstart_serr", seed_err_o, 0);
        check("runstart_sig", sig_o, s);

        // Abort from DONE clears done and stopped, holds state and count.
        do_run('{1'b0, 16'h0000, 16'd50, 1'b1, 8'h01, 0, 2, 1'b1, 1'b0});
        @(posedge clk); #1;
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        check("doneabort_done", done_o, 0);
        check("doneabort_stopped", stopped_o, 0);
        check("doneabort_cnt", cnt_o, 2);
        check("doneabort_sig", sig_o, 16'h0303);

        // Asynchronous reset mid-run clears everything without a clock edge.
        exp_q.push_back(16'hFF00);
        exp_q.push_back(16'hFF01);
        start_run(1'b0, 16'hFF00, 16'd10, 1'b0, 8'h00);
        pat_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_valid", pat_valid_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_done", done_o, 0);
        check("arst_cnt", cnt_o, 0);
        check("arst_sig", sig_o, 0);
        check("arst_flags", {stopped_o, seed_err_o}, 0);
        check("arst_queue", exp_q.size(), 0);
        pat_ready_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
